// File: rtl/comparator_exerciser.sv
// comparator_exerciser: sweeps every {a,b} operand pair through an external comparator
// and records failures, first failing pair and worst settle latency.
module comparator_exerciser #(
   parameter int WIDTH      = 8,
   parameter int SETTLE_MAX = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               eq_in,
   input  logic               gt_in,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH:0]   error_count,
   output logic [7:0]         worst_latency,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_a,
   output logic [WIDTH-1:0]   fail_b
);
   typedef enum logic [2:0] {IDLE, DRIVE, WAIT, NEXT, DONE} state_t;
   localparam logic [7:0] LIMIT = 8'(SETTLE_MAX);
   state_t     state;
   logic [7:0] count;
   logic       match;
   logic       last;
   always_comb begin
      match = ({eq_in, gt_in} == {a_out == b_out, a_out > b_out});
      last  = &{a_out, b_out};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         a_out         <= '0;
         b_out         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error_count   <= '0;
         worst_latency <= '0;
         fail_valid    <= 1'b0;
         fail_a        <= '0;
         fail_b        <= '0;
         count         <= '0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               a_out         <= '0;
               b_out         <= '0;
               error_count   <= '0;
               worst_latency <= '0;
               fail_valid    <= 1'b0;
               fail_a        <= '0;
               fail_b        <= '0;
               count         <= '0;
               busy          <= 1'b1;
               done          <= 1'b0;
               state         <= DRIVE;
            end
            DRIVE: begin
               count <= '0;
               state <= WAIT;
            end
            WAIT: if (match) begin
               if (count > worst_latency) worst_latency <= count;
               state <= NEXT;
            end else if (count == LIMIT) begin
               if (~&error_count) error_count <= error_count + 1'b1;
               if (!fail_valid) begin
                  fail_valid <= 1'b1;
                  fail_a     <= a_out;
                  fail_b     <= b_out;
               end
               state <= NEXT;
            end else begin
               count <= count + 1'b1;
            end
            NEXT: if (last) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end else begin
               // b is the low half, so its wrap carries into a
               {a_out, b_out} <= {a_out, b_out} + 1'b1;
               state          <= DRIVE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/comparator_exerciser.md
COMPARATOR_EXERCISER -- requirements
Module: comparator_exerciser

Interface
REQ-001 Parameter WIDTH, default 8: operand width driven to the comparator under test.
REQ-002 Parameter SETTLE_MAX, default 15, legal range 1..255: last WAIT-cycle index sampled before a vector is declared failed.
REQ-003 One clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  run request; sampled only in IDLE or DONE.
REQ-007 a_out, b_out  output  WIDTH each  registered operands driven to the comparator under test.
REQ-008 eq_in, gt_in  input  1 each  comparator response; a_out==b_out and a_out>b_out (unsigned).
REQ-009 busy  output  1  high in DRIVE, WAIT and NEXT.
REQ-010 done  output  1  high while in DONE.
REQ-011 error_count  output  2*WIDTH+1  number of failed vectors in the current or last run.
REQ-012 worst_latency  output  8  maximum passing-vector latency in the current or last run.
REQ-013 fail_valid  output  1  high once any failure is recorded; fail_a, fail_b  output  WIDTH each  operands of the first failure.

Function
REQ-014 FSM states: IDLE, DRIVE, WAIT, NEXT, DONE; all outputs registered.
REQ-015 IDLE or DONE with start=1: clear a_out, b_out, error_count, worst_latency, fail_valid, fail_a, fail_b and the latency counter; go to DRIVE.
REQ-016 DRIVE: lasts exactly one cycle; clear the latency counter; go to WAIT.
REQ-017 WAIT: each cycle compare {eq_in,gt_in} against the expected pair {a_out==b_out, a_out>b_out}, computed as an unsigned compare.
REQ-018 WAIT match: latency = counter value, where 0 means a match on the first WAIT cycle; worst_latency = max(worst_latency, latency); go to NEXT.
REQ-019 WAIT mismatch with counter==SETTLE_MAX: error_count++ (saturating at all-ones); if fail_valid=0, latch fail_a=a_out, fail_b=b_out and set fail_valid; go to NEXT.
REQ-020 WAIT mismatch with counter<SETTLE_MAX: counter++; stay in WAIT.
REQ-021 Failed vectors do not update worst_latency.
REQ-022 NEXT, {a_out,b_out}==all-ones: go to DONE with operands unchanged.
REQ-023 NEXT, otherwise: increment {a_out,b_out} as one 2*WIDTH counter (b_out is the LSB half, so b wraps 255->0 and carries into a); go to DRIVE.
REQ-024 Sweep order (WIDTH=8): (0,0),(0,1)..(0,255),(1,0)..(255,255); 65536 vectors; each vector is tested exactly once.
REQ-025 A passing vector with latency L occupies 3+L cycles; a failing vector occupies 3+SETTLE_MAX cycles.
REQ-026 start while busy is ignored.
REQ-027 DONE holds all results stable until start or reset.
REQ-028 Simultaneous start and reset: reset wins.

Reset
REQ-029 reset=1 at a rising edge: state=IDLE; a_out=0, b_out=0, busy=0, done=0, error_count=0, worst_latency=0, fail_valid=0, fail_a=0, fail_b=0; takes effect at that edge regardless of state.
REQ-030 Reset mid-run abandons the sweep; a new start is required to run again.

Verification
REQ-031 Ideal zero-delay combinational comparator, WIDTH=8: pulse start -> done first high 196608 edges after the start-sampling edge; error_count=0, worst_latency=0, fail_valid=0.
REQ-032 Comparator behind 3 register stages -> error_count=0, worst_latency=2, done=1.
REQ-033 gt_in stuck at 0 -> error_count=32640, fail_valid=1, fail_a=1, fail_b=0, worst_latency=0.
REQ-034 Comparator behind 20 register stages with SETTLE_MAX=15 -> every vector whose expected result differs from the stale response fails; error_count>0; worst_latency<=15.
REQ-035 reset asserted at vector (3,7) during WAIT -> next cycle all outputs at reset values, busy=0; start held 5 cycles after reset -> sweep restarts at (0,0) exactly once.
REQ-036 start pulsed while busy -> sweep unchanged; start pulsed in DONE -> counters cleared and a second full sweep reproduces identical results.
